// File: rtl/beat_sequencer.sv
// Run-control for the four-beat instruction cycle: one-hot T1..T4, run/step/stop/halt, memory stalls, instruction count.
// Latency: start/step show up on t at the sampling edge; mem_wait freezes the beat and all latches for as long as it is high.
module beat_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             stop,
    input  logic             halt_op,
    input  logic             mem_wait,
    output logic [3:0]       t,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] icount,
    output logic             cycle_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam logic [3:0] T1 = 4'b0001;
    localparam logic [3:0] T2 = 4'b0010;
    localparam logic [3:0] T4 = 4'b1000;

    state_t             state_q, state_d;
    logic [3:0]         t_q, t_d;
    logic               stop_pend_q, stop_pend_d;
    logic               halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0]   icount_q, icount_d;
    logic               cycle_done_q, cycle_done_d;
    logic               running_q, running_d;
    logic               halted_q, halted_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            t_q          <= '0;
            stop_pend_q  <= 1'b0;
            halt_pend_q  <= 1'b0;
            icount_q     <= '0;
            cycle_done_q <= 1'b0;
            running_q    <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            stop_pend_q  <= stop_pend_d;
            halt_pend_q  <= halt_pend_d;
            icount_q     <= icount_d;
            cycle_done_q <= cycle_done_d;
            running_q    <= running_d;
            halted_q     <= halted_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        t_d          = t_q;
        stop_pend_d  = stop_pend_q;
        halt_pend_d  = halt_pend_q;
        icount_d     = icount_q;
        cycle_done_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    t_d     = T1;
                end else if (step) begin
                    state_d = S_STEP;
                    t_d     = T1;
                end
            end
            S_RUN, S_STEP: begin
                if (!mem_wait) begin
                    if (state_q == S_RUN && stop)
                        stop_pend_d = 1'b1;
                    if (t_q == T2 && halt_op)
                        halt_pend_d = 1'b1;
                    if (t_q == T4) begin
                        // Instruction boundary: halt beats single-step beats stop.
                        icount_d     = icount_q + CNT_W'(1);
                        cycle_done_d = 1'b1;
                        stop_pend_d  = 1'b0;
                        halt_pend_d  = 1'b0;
                        if (halt_pend_q) begin
                            state_d = S_HALT;
                            t_d     = '0;
                        end else if (state_q == S_STEP || stop_pend_q || stop) begin
                            state_d = S_IDLE;
                            t_d     = '0;
                        end else begin
                            t_d = T1;
                        end
                    end else begin
                        t_d = {t_q[2:0], 1'b0};
                    end
                end
            end
            S_HALT: begin
                if (start) begin
                    state_d = S_RUN;
                    t_d     = T1;
                end
            end
            default: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
        endcase
    end

    always_comb begin
        running_d = (state_d == S_RUN) || (state_d == S_STEP);
        halted_d  = (state_d == S_HALT);
    end

    assign t          = t_q;
    assign running    = running_q;
    assign halted     = halted_q;
    assign icount     = icount_q;
    assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer with a 4-bit instruction counter so wraparound is reachable.
module tb_beat_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       step = 1'b0;
    logic       stop = 1'b0;
    logic       halt_op = 1'b0;
    logic       mem_wait = 1'b0;
    logic [3:0] t;
    logic       running;
    logic       halted;
    logic [3:0] icount;
    logic       cycle_done;

    int vectors = 0;
    int miscompares = 0;

    beat_sequencer #(.CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .step       (step),
        .stop       (stop),
        .halt_op    (halt_op),
        .mem_wait   (mem_wait),
        .t          (t),
        .running    (running),
        .halted     (halted),
        .icount     (icount),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held for three cycles
        #2 rst = 1'b0;
        repeat (3) tick();
        chk("rst_t", 32'(t), 32'h0);
        chk("rst_running", 32'(running), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_icount", 32'(icount), 32'h0);
        chk("rst_cycle_done", 32'(cycle_done), 32'h0);
        rst = 1'b1;
        tick();
        chk("idle_t", 32'(t), 32'h0);

        // Start, then reset during T3 aborts without counting
        start = 1'b1;
        tick();
        chk("start_t", 32'(t), 32'h1);
        chk("start_running", 32'(running), 32'h1);
        start = 1'b0;
        tick();
        tick();
        chk("abort_pre_t", 32'(t), 32'h4);
        rst = 1'b0;
        #1;
        chk("abort_t", 32'(t), 32'h0);
        chk("abort_running", 32'(running), 32'h0);
        chk("abort_icount", 32'(icount), 32'h0);
        tick();
        rst = 1'b1;
        tick();

        // Free run: beats, first completion, three completions
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_t1", 32'(t), 32'h1);
        tick();
        chk("run_t2", 32'(t), 32'h2);
        chk("run_cd_low", 32'(cycle_done), 32'h0);
        tick();
        chk("run_t3", 32'(t), 32'h4);
        tick();
        chk("run_t4", 32'(t), 32'h8);
        tick();
        chk("run_wrap_t1", 32'(t), 32'h1);
        chk("run_icount1", 32'(icount), 32'h1);
        chk("run_cd_pulse", 32'(cycle_done), 32'h1);
        tick();
        chk("run_cd_clear", 32'(cycle_done), 32'h0);
        repeat (7) tick();
        chk("run_icount3", 32'(icount), 32'h3);
        chk("run_cd3", 32'(cycle_done), 32'h1);

        // Stop pulse during T2 finishes the instruction, then idles
        tick();
        chk("stop_at_t2", 32'(t), 32'h2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_t3", 32'(t), 32'h4);
        tick();
        chk("stop_t4", 32'(t), 32'h8);
        tick();
        chk("stop_t", 32'(t), 32'h0);
        chk("stop_running", 32'(running), 32'h0);
        chk("stop_icount", 32'(icount), 32'h4);
        chk("stop_cd", 32'(cycle_done), 32'h1);
        tick();
        chk("stop_idle_t", 32'(t), 32'h0);
        chk("stop_idle_cd", 32'(cycle_done), 32'h0);

        // Single step twice
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("step_t1", 32'(t), 32'h1);
        chk("step_running", 32'(running), 32'h1);
        repeat (3) tick();
        chk("step_t4", 32'(t), 32'h8);
        tick();
        chk("step_end_t", 32'(t), 32'h0);
        chk("step_end_running", 32'(running), 32'h0);
        chk("step_icount", 32'(icount), 32'h5);
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (4) tick();
        chk("step2_t", 32'(t), 32'h0);
        chk("step2_icount", 32'(icount), 32'h6);

        // Stall: T1 held for four cycles, instruction takes seven clocks
        start = 1'b1;
        tick();
        start = 1'b0;
        mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall_hold%0d", i), 32'(t), 32'h1);
            chk($sformatf("stall_cd%0d", i), 32'(cycle_done), 32'h0);
        end
        mem_wait = 1'b0;
        tick();
        chk("stall_t2", 32'(t), 32'h2);
        tick();
        tick();
        chk("stall_t4", 32'(t), 32'h8);
        chk("stall_icount_before", 32'(icount), 32'h6);
        tick();
        chk("stall_next_t1", 32'(t), 32'h1);
        chk("stall_icount", 32'(icount), 32'h7);

        // HLT flagged at T2 parks in HALT after T4
        tick();
        chk("hlt_at_t2", 32'(t), 32'h2);
        halt_op = 1'b1;
        tick();
        halt_op = 1'b0;
        tick();
        tick();
        chk("hlt_t", 32'(t), 32'h0);
        chk("hlt_halted", 32'(halted), 32'h1);
        chk("hlt_running", 32'(running), 32'h0);
        chk("hlt_icount", 32'(icount), 32'h8);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("hlt_step_ignored_t", 32'(t), 32'h0);
        chk("hlt_step_ignored_halted", 32'(halted), 32'h1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("resume_t", 32'(t), 32'h1);
        chk("resume_halted", 32'(halted), 32'h0);
        chk("resume_running", 32'(running), 32'h1);

        // Counter wraps 15 -> 0 with CNT_W=4
        for (int n = 1; n <= 8; n++) begin
            repeat (4) tick();
            chk($sformatf("wrap_icount%0d", n), 32'(icount), 32'((8 + n) % 16));
        end
        chk("wrap_t", 32'(t), 32'h1);

        // Stop held across T1 idles at the boundary
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (3) tick();
        chk("stop2_t", 32'(t), 32'h0);
        chk("stop2_icount", 32'(icount), 32'h1);

        // start and step together choose RUN, which continues past T4
        start = 1'b1;
        step  = 1'b1;
        tick();
        start = 1'b0;
        step  = 1'b0;
        chk("both_t", 32'(t), 32'h1);
        chk("both_running", 32'(running), 32'h1);
        repeat (4) tick();
        chk("both_continue_t", 32'(t), 32'h1);
        chk("both_continue_running", 32'(running), 32'h1);
        chk("both_icount", 32'(icount), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/beat_sequencer.md
# beat_sequencer

Run-control block for the CPU's four-beat instruction cycle. It produces the one-hot beat vector t[3:0] (T1..T4) that sequences fetch, decode, execute and writeback. It adds free-run, single-step, stop-at-boundary, HLT-instruction halt and memory-wait stalls, and counts completed instructions. It sits between the front-panel/debug controls and the control unit, replacing a free-running beat source.

## Interface
- CNT_W, 16, width of the completed-instruction counter icount.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level sampled each cycle. Enters RUN from IDLE or HALT.
- step  in  1  level sampled each cycle. Executes exactly one instruction cycle from IDLE.
- stop  in  1  request to leave RUN at the next instruction boundary.
- halt_op  in  1  decoder flag: the current instruction is HLT. Valid during T2.
- mem_wait  in  1  memory not ready. Holds the current beat.
- t  out  4  one-hot beat: 0001=T1, 0010=T2, 0100=T3, 1000=T4; 0000 when no cycle is active.
- running  out  1  high in RUN or STEP.
- halted  out  1  high in HALT.
- icount  out  CNT_W  completed instruction cycles, wraps modulo 2^CNT_W.
- cycle_done  out  1  one-cycle pulse after each completed T4.

## Operation
- States: IDLE, RUN, STEP, HALT (2-bit encoded register).
- Beat advance in RUN/STEP with mem_wait=0: T1→T2→T3→T4→boundary.
- mem_wait=1 in any beat: t, state and latches hold. cycle_done stays 0.
- IDLE (t=0000):
  - start=1 → RUN, t=0001.
  - else step=1 → STEP, t=0001.
  - start and step together: start wins.
  - stop and halt_op are ignored.
- RUN, stop handling: stop=1 in any cycle sets stop_pend. It stays set until the boundary.
- RUN/STEP, HLT detection: halt_op is sampled only when t=0010 and mem_wait=0; if set it sets halt_pend.
- Boundary (t=1000, mem_wait=0), evaluated in this priority order:
  - halt_pend → HALT, t=0000.
  - else STEP → IDLE, t=0000.
  - else stop_pend, or stop=1 on this same cycle → IDLE, t=0000.
  - else RUN continues, t=0001.
- At every boundary:
  - icount increments by 1, all-ones wraps to 0.
  - cycle_done=1 on the following cycle only.
  - stop_pend and halt_pend clear.
- HALT (t=0000, halted=1):
  - start=1 → RUN, t=0001, halted=0.
  - step and stop are ignored.
- start/step asserted while RUN or STEP: ignored. No restart mid-cycle.
- running = (state==RUN) or (state==STEP). halted = (state==HALT). Both are registered with state.

## Timing
- Reset (rst=0, asynchronous, immediate): state=IDLE, t=0000, running=0, halted=0, icount=0, cycle_done=0, stop_pend=0, halt_pend=0.
- Reset mid-cycle aborts the instruction with no icount increment. Release is sampled at the next posedge.
- Start latency: start high at edge k → t=0001 and running=1 from edge k.
- Unstalled instruction cycle: exactly 4 clocks. Each mem_wait cycle adds 1 clock.
- Back-to-back RUN: T4 is followed directly by T1. No idle beat.
- cycle_done and the new icount value become visible together, on the edge that ends T4.
  - Note: cycle_done is registered, so it is high during the cycle after T4, which in RUN is the next T1.
- Exit to IDLE or HALT: t=0000 and running=0 from the edge that ends T4.
- t is always one-hot or zero. No other values are reachable.

## Test plan
- Reset then free run:
  - Stimulus: rst low 3 cycles, release, start=1 one cycle.
  - Response: t = 0001,0010,0100,1000,0001…; icount = 1 after the 4th beat edge, 3 after 12 beats; cycle_done pulses every 4 cycles.
- Single step:
  - Stimulus: step=1 one cycle from IDLE.
  - Response: exactly T1..T4, then t=0000, running=0, icount=1. A second step gives icount=2.
- Stall:
  - Stimulus: mem_wait=1 for 3 cycles during T1.
  - Response: t holds 0001 for 4 cycles total; the instruction takes 7 clocks; icount increments once.
- Stop and halt:
  - Stimulus: stop pulse during T2 of RUN.
    - Response: finishes T3, T4, then IDLE with icount +1.
  - Stimulus: halt_op=1 at T2.
    - Response: HALT after T4, halted=1; start then resumes at T1.
- Boundaries:
  - Stimulus: preload icount via CNT_W=4 and run 16 cycles.
    - Response: icount wraps 15→0.
  - Stimulus: start and step together.
    - Response: RUN.
  - Stimulus: rst asserted during T3.
    - Response: immediate t=0000, icount unchanged.
